// File: rtl/impl_pkg.sv
// ---------------------------------------------------------------------------
// impl_pkg
// Shared types for the implication checker: the bitwise function select
// encoding and the frame FSM states.
// ---------------------------------------------------------------------------
package impl_pkg;

    // Bitwise function applied to (a, b) on every beat of a frame.
    typedef enum logic [1:0] {
        IMP  = 2'b00,   // ~a | b
        CONV = 2'b01,   //  a | ~b
        NIMP = 2'b10,   //  a & ~b
        XNOR = 2'b11    // ~(a ^ b)
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/impl_bitop.sv
// ---------------------------------------------------------------------------
// impl_bitop
// Purely combinational bitwise function unit.
//   a, b   : WIDTH-bit operands
//   op     : function select (impl_pkg::op_e encoding)
//   result : WIDTH-bit per-bit function of a and b
// ---------------------------------------------------------------------------
module impl_bitop
    import impl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op_e'(op))
            IMP:     result = ~a | b;
            CONV:    result = a | ~b;
            NIMP:    result = a & ~b;
            XNOR:    result = ~(a ^ b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/impl_checker.sv
// ---------------------------------------------------------------------------
// impl_checker
// Accumulates a frame of operand beats through a selectable bitwise function
// and reports the per-bit AND of all results plus a saturating count of zero
// result bits.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : beat handshake (in_ready low while reporting)
//   a, b, op, in_last    : operands, function select, end-of-frame marker
//   out_valid / out_ready: frame report handshake
//   out_vec              : per-bit AND of all beat results in the frame
//   frame_ok             : every result bit of the frame was 1
//   viol_cnt             : saturating count of zero result bits
// ---------------------------------------------------------------------------
module impl_checker
    import impl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic             frame_ok,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam int ZW = $clog2(WIDTH + 1);
    // Sum width wide enough that neither operand of the add can overflow it.
    localparam int SW = ((CNT_W > ZW) ? CNT_W : ZW) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    state_e           r_state;
    state_e           w_state_nxt;
    op_e              r_op;
    op_e              w_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_res;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ZW-1:0]    w_zeros;
    logic [SW-1:0]    w_sum;
    logic             w_accept;
    logic             w_report_done;

    assign in_ready      = (r_state != REPORT);
    assign out_valid     = (r_state == REPORT);
    assign w_accept      = in_valid & in_ready;
    assign w_report_done = out_valid & out_ready;

    // The first beat of a frame uses the live op; later beats use the held one.
    assign w_op = (r_state == IDLE) ? op_e'(op) : r_op;

    impl_bitop #(
        .WIDTH(WIDTH)
    ) u_bitop (
        .a      (a),
        .b      (b),
        .op     (w_op),
        .result (w_res)
    );

    always_comb begin
        w_zeros = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!w_res[i]) w_zeros = w_zeros + ZW'(1);
        end
        w_sum     = SW'(r_cnt) + SW'(w_zeros);
        w_cnt_nxt = (w_sum > CNT_MAX) ? '1 : w_sum[CNT_W-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) w_state_nxt = in_last ? REPORT : ACCUM;
            end
            REPORT: begin
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '1;
            r_cnt <= '0;
            r_op  <= IMP;
        end else if (w_report_done) begin
            r_acc <= '1;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= r_acc & w_res;
            r_cnt <= w_cnt_nxt;
            r_op  <= w_op;
        end
    end

    assign out_vec  = r_acc;
    assign viol_cnt = r_cnt;
    assign frame_ok = out_valid & (r_cnt == '0);

endmodule

// File: tb/tb_impl_checker.sv
// ---------------------------------------------------------------------------
// tb_impl_checker
// Self-checking bench for impl_checker. Two instances share all inputs: one
// with the default counter width and one with a 4-bit counter so saturation
// is exercised on the same traffic.
// ---------------------------------------------------------------------------
module tb_impl_checker;
    import impl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] op = '0;

    logic        in_ready0, out_valid0, frame_ok0;
    logic [7:0]  out_vec0;
    logic [15:0] viol0;
    logic        in_ready1, out_valid1, frame_ok1;
    logic [7:0]  out_vec1;
    logic [3:0]  viol1;

    impl_checker #(.WIDTH(8), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .op(op), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_vec(out_vec0),
        .frame_ok(frame_ok0), .viol_cnt(viol0)
    );

    impl_checker #(.WIDTH(8), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_vec(out_vec1),
        .frame_ok(frame_ok1), .viol_cnt(viol1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Truth table per op, indexed by {a_bit, b_bit}.
    logic [3:0] tt [4] = '{4'b1011, 4'b1101, 4'b0100, 4'b1001};

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] ev;
        int         zeros;
    } vec_t;

    beat_t frame_q[$];
    vec_t  tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] spec_fn(input logic [7:0] x, input logic [7:0] y,
                                           input logic [1:0] f);
        logic [3:0] t;
        logic [7:0] r;
        t = tt[f];
        for (int i = 0; i < 8; i++) r[i] = t[{x[i], y[i]}];
        return r;
    endfunction

    task automatic model(output logic [7:0] ev, output int z);
        logic [1:0] f;
        logic [7:0] r;
        f  = frame_q[0].op;
        ev = 8'hFF;
        z  = 0;
        foreach (frame_q[k]) begin
            r  = spec_fn(frame_q[k].a, frame_q[k].b, f);
            ev = ev & r;
            z  = z + 8 - $countones(r);
        end
    endtask

    task automatic send_beat(input beat_t bt, input int gap_max);
        repeat ($urandom_range(0, gap_max)) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); in_last = 1'($urandom);
        end
        @(negedge clk);
        chk("beat_in_ready0", in_ready0, 1);
        chk("beat_in_ready1", in_ready1, 1);
        in_valid = 1'b1;
        a = bt.a; b = bt.b; op = bt.op; in_last = bt.last;
        @(posedge clk);
    endtask

    task automatic send_frame(input int gap_max);
        foreach (frame_q[k]) send_beat(frame_q[k], gap_max);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at the negedge after the last beat was accepted.
    task automatic check_report(input logic [7:0] ev, input int z, input int hold);
        logic [15:0] e0;
        logic [3:0]  e1;
        logic        ok;
        e0 = (z > 65535) ? 16'hFFFF : 16'(z);
        e1 = (z > 15) ? 4'hF : 4'(z);
        ok = (z == 0);
        chk("rpt_valid0", out_valid0, 1);
        chk("rpt_valid1", out_valid1, 1);
        chk("rpt_vec0", out_vec0, ev);
        chk("rpt_vec1", out_vec1, ev);
        chk("rpt_cnt0", viol0, e0);
        chk("rpt_cnt1", viol1, e1);
        chk("rpt_ok0", frame_ok0, ok);
        chk("rpt_ok1", frame_ok1, ok);
        chk("rpt_in_ready0", in_ready0, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); in_last = 1'($urandom);
            @(negedge clk);
            chk("hold_valid0", out_valid0, 1);
            chk("hold_in_ready0", in_ready0, 0);
            chk("hold_vec0", out_vec0, ev);
            chk("hold_cnt0", viol0, e0);
            chk("hold_cnt1", viol1, e1);
            chk("hold_ok0", frame_ok0, ok);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid0", out_valid0, 0);
        chk("post_in_ready0", in_ready0, 1);
        chk("post_in_ready1", in_ready1, 1);
        chk("post_vec0", out_vec0, 8'hFF);
        chk("post_cnt0", viol0, 0);
        chk("post_cnt1", viol1, 0);
        chk("post_ok0", frame_ok0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready0"}, in_ready0, 1);
        chk({tag, "_valid0"}, out_valid0, 0);
        chk({tag, "_valid1"}, out_valid1, 0);
        chk({tag, "_vec0"}, out_vec0, 8'hFF);
        chk({tag, "_cnt0"}, viol0, 0);
        chk({tag, "_cnt1"}, viol1, 0);
        chk({tag, "_ok0"}, frame_ok0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] ev;
        int         z;
        int         len;
        beat_t      bt;

        tbl[0] = '{8'hF0, 8'h30, 2'b00, 8'h3F, 2};
        tbl[1] = '{8'hF0, 8'h30, 2'b01, 8'hFF, 0};
        tbl[2] = '{8'hF0, 8'h30, 2'b10, 8'hC0, 6};
        tbl[3] = '{8'hF0, 8'h30, 2'b11, 8'h3F, 2};
        tbl[4] = '{8'hFF, 8'h00, 2'b00, 8'h00, 8};
        tbl[5] = '{8'h00, 8'hFF, 2'b01, 8'h00, 8};
        tbl[6] = '{8'h5A, 8'h5A, 2'b11, 8'hFF, 0};

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("after_reset");

        // Single-beat frames from the table.
        for (int t = 0; t < 7; t++) begin
            frame_q = {};
            frame_q.push_back('{tbl[t].a, tbl[t].b, tbl[t].op, 1'b1});
            send_frame(0);
            check_report(tbl[t].ev, tbl[t].zeros, 0);
        end

        // op change after first beat must be ignored.
        frame_q = {};
        frame_q.push_back('{8'h00, 8'($urandom), 2'b00, 1'b0});
        frame_q.push_back('{8'h00, 8'($urandom), 2'b10, 1'b0});
        frame_q.push_back('{8'h00, 8'($urandom), 2'b10, 1'b1});
        send_frame(0);
        check_report(8'hFF, 0, 0);

        // XNOR two-beat frame.
        frame_q = {};
        frame_q.push_back('{8'hAA, 8'hAA, 2'b11, 1'b0});
        frame_q.push_back('{8'hAA, 8'h55, 2'b11, 1'b1});
        send_frame(0);
        check_report(8'h00, 8, 0);

        // Backpressure: 5 cycles of out_ready=0 with in_valid held high.
        frame_q = {};
        frame_q.push_back('{8'hF0, 8'h30, 2'b00, 1'b1});
        send_frame(0);
        check_report(8'h3F, 2, 5);

        // Saturation on the 4-bit counter: 24 zero bits.
        frame_q = {};
        for (int k = 0; k < 3; k++) frame_q.push_back('{8'h00, 8'h00, 2'b10, k == 2});
        send_frame(0);
        check_report(8'h00, 24, 0);

        // Reset after beat 2 discards the frame.
        send_beat('{8'h00, 8'h00, 2'b10, 1'b0}, 0);
        send_beat('{8'h00, 8'h00, 2'b10, 1'b0}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_cnt0", viol0, 16);
        chk("mid_cnt1", viol1, 15);
        rst_n = 1'b0;
        #2;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("no_report");
        end
        frame_q = {};
        frame_q.push_back('{8'hF0, 8'h30, 2'b00, 1'b1});
        send_frame(0);
        check_report(8'h3F, 2, 0);

        // Randomized frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            frame_q = {};
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                bt.a    = 8'($urandom);
                bt.b    = 8'($urandom);
                bt.op   = 2'($urandom);
                bt.last = (k == len - 1);
                frame_q.push_back(bt);
            end
            model(ev, z);
            send_frame(2);
            check_report(ev, z, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/impl_checker.md
IMPL_CHECKER -- requirements
Module: impl_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits (WIDTH >= 1).
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the violation-counter width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: an operand beat is offered.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The module SHALL have port a, input, WIDTH bits: first operand.
REQ-008 The module SHALL have port b, input, WIDTH bits: second operand.
REQ-009 The module SHALL have port op, input, 2 bits: bitwise function select.
REQ-010 The module SHALL have port in_last, input, 1 bit: the offered beat ends the frame.
REQ-011 The module SHALL have port out_valid, output, 1 bit: the frame report is presented.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer takes the report.
REQ-013 The module SHALL have port out_vec, output, WIDTH bits: per-bit AND of all beat results in the frame.
REQ-014 The module SHALL have port frame_ok, output, 1 bit: every bit of every beat evaluated to 1.
REQ-015 The module SHALL have port viol_cnt, output, CNT_W bits: total number of 0 result bits in the frame.

Function
REQ-016 The op encoding SHALL be: 00 IMP (~a|b); 01 CONV (a|~b); 10 NIMP (a&~b); 11 XNOR (~(a^b)).
REQ-017 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-018 The FSM SHALL have three states, IDLE, ACCUM and REPORT; in_ready SHALL be 1 in IDLE and ACCUM and 0 in REPORT.
REQ-019 op SHALL be sampled on the first accepted beat of a frame and held for the whole frame; op changes on later beats SHALL be ignored.
REQ-020 On each accepted beat, the accumulated vector SHALL become acc_vec & result, and the count SHALL increase by the number of 0 bits in result.
REQ-021 The count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 Transition IDLE->ACCUM SHALL occur on an accepted beat with in_last=0.
REQ-023 Transition IDLE->REPORT or ACCUM->REPORT SHALL occur on an accepted beat with in_last=1; a single-beat frame is legal.
REQ-024 out_valid SHALL assert the cycle after the last beat is accepted (latency 1 cycle).
REQ-025 While out_valid=1, out_vec, frame_ok and viol_cnt SHALL be registered and held stable until out_ready=1.
REQ-026 While out_valid=0, frame_ok SHALL be 0.
REQ-027 frame_ok SHALL equal (count==0) for the reported frame.
REQ-028 On the REPORT handshake (out_valid & out_ready), the accumulators SHALL clear (out_vec all ones, count 0) and the FSM SHALL go to IDLE; in_ready SHALL rise the next cycle.
REQ-029 in_valid asserted while in REPORT SHALL have no effect.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, out_valid=0, frame_ok=0, viol_cnt=0, out_vec all ones, held op=IMP.
REQ-031 A reset asserted mid-frame or during REPORT SHALL discard the frame with no partial report.

Structure
REQ-032 A shared package impl_pkg SHALL hold the op enumeration (IMP, CONV, NIMP, XNOR) and the FSM state enumeration.
REQ-033 The bitwise function SHALL be a combinational sub-module impl_bitop (inputs a, b, op; output WIDTH-bit result); the popcount and FSM SHALL live in impl_checker.

Verification (WIDTH=8 unless stated)
REQ-034 Reset: after reset -> in_ready=1, out_valid=0, out_vec=8'hFF, viol_cnt=0, frame_ok=0.
REQ-035 Single-beat IMP, a=8'hF0, b=8'h30, in_last=1 -> next cycle out_valid=1, out_vec=8'h3F, viol_cnt=2, frame_ok=0.
REQ-036 3-beat IMP frame with a=8'h00 and arbitrary b, op changed to NIMP on beat 2 -> out_vec=8'hFF, viol_cnt=0, frame_ok=1.
REQ-037 XNOR frame: (a=8'hAA, b=8'hAA) then (a=8'hAA, b=8'h55) last -> out_vec=8'h00, viol_cnt=8.
REQ-038 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, in_ready=0, no beats accepted; then out_ready=1 -> next cycle in_ready=1, out_vec=8'hFF.
REQ-039 CNT_W=4: 3-beat NIMP frame, a=b=0 -> viol_cnt=15 (saturated); a second run with rst_n pulsed low after beat 2 -> no report, reset values.
